sw_pair_pwm_ctrl: RTL and testbench
===================================

Name: sw_pair_pwm_ctrl

Overview:
Digital switch controller that generates the sw1/sw2 gate commands for the switched-circuit analog model and monitors the model's fixed-point v_out code for over-voltage.
- Sits on the digital side of the emulation testbench: drives the model's sw1/sw2 inputs and consumes its fixed-point v_out.
- Produces a complementary, non-overlapping PWM pair with programmable period, duty and dead time.
- Latches a fault and disables both switches when v_out exceeds a threshold; the fault clears with hysteresis.

Parameters:
- CNT_W, 16, width of period/duty counters.
- DT_W, 8, width of dead-time field.
- V_W, 25, width of signed fixed-point v_out code. Same exponent as ov_thresh/ov_clear; the comparison is plain signed integer.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request.
- period  in  CNT_W  PWM period in clk cycles (unsigned).
- duty  in  CNT_W  sw1 on-time in cycles (unsigned).
- dead  in  DT_W  dead time in cycles (unsigned).
- v_out_code  in  V_W  signed fixed-point model output.
- ov_thresh  in  V_W  signed fault-set threshold.
- ov_clear  in  V_W  signed fault-clear threshold (must be ≤ ov_thresh).
- sw1  out  1  high-side switch command.
- sw2  out  1  low-side switch command.
- fault  out  1  over-voltage latched.
- cycle_start  out  1  one-cycle pulse when cnt==0 in RUN.
- busy  out  1  high in RUN.

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, cnt=0, shadow regs=0. sw1, sw2, fault, cycle_start and busy are all 0. Reset takes precedence over everything, including mid-period and in FAULT.
- States: IDLE, RUN, FAULT.
- Shadow registers:
  - period_l, duty_l and dead_l are loaded from the inputs on IDLE->RUN and at every terminal count (cnt==period_l-1) while staying in RUN.
  - Input changes mid-period have no effect until the next period.
  - duty_eff = min(duty_l, period_l).
- IDLE->RUN: when en=1, period≥2 and v_out_code<ov_thresh at an edge. The first RUN cycle has cnt=0 and cycle_start=1. period<2 keeps the block in IDLE.
- RUN:
  - cnt increments by 1 each cycle and wraps period_l-1 -> 0.
  - cycle_start=1 exactly when cnt==0.
- Outputs are flops, valid in the same cycle as the cnt value they describe:
  - sw1 = (cnt < duty_eff).
  - sw2 = (cnt ≥ duty_eff+dead_l) && (cnt < period_l-dead_l). Compute the sums at CNT_W+1 bits, no wrap.
  - If duty_eff+dead_l ≥ period_l-dead_l, or dead_l ≥ period_l, sw2 stays 0 for the whole period.
  - Invariant: sw1 & sw2 is never 1, in any state or parameter combination.
- en deasserted in RUN: the current period completes, then the block goes to IDLE at the edge ending cnt==period_l-1. Outputs are 0 in IDLE.
- RUN->FAULT: sampled v_out_code ≥ ov_thresh (signed) at any edge in RUN.
  - Next cycle: sw1=sw2=0, fault=1, busy=0, cnt=0.
  - Fault has priority over terminal count, en drop and shadow reload.
- IDLE->FAULT: same compare while en=1.
- FAULT->IDLE: when v_out_code ≤ ov_clear and en=0 at the same edge. fault drops the next cycle.
  - en=1 holds FAULT regardless of voltage, so re-arm requires an explicit en toggle.
- busy=1 iff state==RUN.

Test Plan:
- Basic PWM: period=10, duty=4, dead=1, en held 1 → per period sw1=1 at cnt0–3, sw2=1 at cnt5–8, both 0 at cnt4 and cnt9. cycle_start every 10 cycles. First sw1=1 is in the cycle after the en-sampling edge.
- Boundaries:
  - duty=0 → sw1 never high; sw2 high cnt1–8.
  - duty=12, period=10 → sw1 high all 10 cycles, sw2 never.
  - dead=5, period=10, duty=4 → sw2 never.
  - period=1 → block stays IDLE.
- Mid-period update: in a period=10 run, change to period=6, duty=2 at cnt=3 → current period unchanged. The next period has length 6 with sw1 at cnt0–1 and sw2 at cnt3–4.
- Graceful stop: drop en at cnt=2 → outputs continue to cnt=9, then all 0 and busy=0.
- Over-voltage (ov_thresh=1000, ov_clear=800):
  - Drive v_out_code=1000 at cnt=1 → next cycle sw1=sw2=0, fault=1.
  - v_out_code=900 with en=0 → stays FAULT.
  - v_out_code=800 with en=1 → stays FAULT.
  - v_out_code=800 with en=0 → IDLE, fault=0.
- Reset mid-RUN at cnt=5 with sw2 active → next cycle all outputs 0, state IDLE. Random parameter sweep (1k periods) confirms sw1&sw2 is never 1.

Source files
------------

// File: rtl/sw_pair_pwm_ctrl.sv
// Complementary non-overlapping PWM pair for sw1/sw2 with programmable period/duty/dead time,
// plus a latched over-voltage fault on the model's signed v_out code (clears with hysteresis).
module sw_pair_pwm_ctrl #(
  parameter int CNT_W = 16,
  parameter int DT_W  = 8,
  parameter int V_W   = 25
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [CNT_W-1:0]        period,
  input  logic [CNT_W-1:0]        duty,
  input  logic [DT_W-1:0]         dead,
  input  logic signed [V_W-1:0]   v_out_code,
  input  logic signed [V_W-1:0]   ov_thresh,
  input  logic signed [V_W-1:0]   ov_clear,
  output logic                    sw1,
  output logic                    sw2,
  output logic                    fault,
  output logic                    cycle_start,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_l_q, period_l_d;
  logic [CNT_W-1:0] duty_l_q, duty_l_d;
  logic [DT_W-1:0]  dead_l_q, dead_l_d;
  logic             sw1_q, sw1_d;
  logic             sw2_q, sw2_d;
  logic             fault_q, fault_d;
  logic             cycle_start_q, cycle_start_d;
  logic             busy_q, busy_d;

  logic             ov_hit, ov_clr, terminal, load, run_d;
  logic [CNT_W-1:0] duty_eff;
  logic [CNT_W:0]   dead_ext, on_end, off_start;
  logic             sw2_win;

  always_comb begin
    ov_hit   = (v_out_code >= ov_thresh);
    ov_clr   = (v_out_code <= ov_clear);
    terminal = (cnt_q == period_l_q - ONE);
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;

    // Fault takes priority over terminal count, en drop and shadow reload.
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en && ov_hit) begin
          state_d = FAULT;
        end else if (en && (period > ONE)) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (ov_hit) begin
          state_d = FAULT;
          cnt_d   = '0;
        end else if (terminal) begin
          cnt_d = '0;
          if (en) load = 1'b1;
          else    state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      FAULT: begin
        cnt_d = '0;
        if (ov_clr && !en) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    period_l_d = load ? period : period_l_q;
    duty_l_d   = load ? duty   : duty_l_q;
    dead_l_d   = load ? dead   : dead_l_q;

    // Outputs describe the upcoming cycle, so they are decoded from the next count and shadows.
    duty_eff  = (duty_l_d < period_l_d) ? duty_l_d : period_l_d;
    dead_ext  = {{(CNT_W+1-DT_W){1'b0}}, dead_l_d};
    on_end    = {1'b0, duty_eff} + dead_ext;
    off_start = {1'b0, period_l_d} - dead_ext;
    sw2_win   = (dead_ext < {1'b0, period_l_d}) &&
                ({1'b0, cnt_d} >= on_end) && ({1'b0, cnt_d} < off_start);

    run_d         = (state_d == RUN);
    sw1_d         = run_d && (cnt_d < duty_eff);
    sw2_d         = run_d && sw2_win;
    fault_d       = (state_d == FAULT);
    busy_d        = run_d;
    cycle_start_d = run_d && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      period_l_q    <= '0;
      duty_l_q      <= '0;
      dead_l_q      <= '0;
      sw1_q         <= 1'b0;
      sw2_q         <= 1'b0;
      fault_q       <= 1'b0;
      cycle_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      period_l_q    <= period_l_d;
      duty_l_q      <= duty_l_d;
      dead_l_q      <= dead_l_d;
      sw1_q         <= sw1_d;
      sw2_q         <= sw2_d;
      fault_q       <= fault_d;
      cycle_start_q <= cycle_start_d;
      busy_q        <= busy_d;
    end
  end

  assign sw1         = sw1_q;
  assign sw2         = sw2_q;
  assign fault       = fault_q;
  assign cycle_start = cycle_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sw_pair_pwm_ctrl.sv
// Scoreboard bench: a per-edge behavioural model queues expected outputs, a negedge monitor compares.
module tb_sw_pair_pwm_ctrl;

  localparam int CNT_W = 16;
  localparam int DT_W  = 8;
  localparam int V_W   = 25;

  logic                  clk;
  logic                  rst, en;
  logic [CNT_W-1:0]      period, duty;
  logic [DT_W-1:0]       dead;
  logic signed [V_W-1:0] v_out_code, ov_thresh, ov_clear;
  logic                  sw1, sw2, fault, cycle_start, busy;

  sw_pair_pwm_ctrl #(.CNT_W(CNT_W), .DT_W(DT_W), .V_W(V_W)) dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .duty(duty), .dead(dead),
    .v_out_code(v_out_code), .ov_thresh(ov_thresh), .ov_clear(ov_clear),
    .sw1(sw1), .sw2(sw2), .fault(fault), .cycle_start(cycle_start), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];

  // Model: running/faulted flags, position within the period and the latched period settings.
  bit m_run = 1'b0;
  bit m_flt = 1'b0;
  int m_pos = 0;
  int m_p = 0, m_d = 0, m_t = 0;

  function automatic logic [1:0] pwm_pair(input int pos, input int p, input int d, input int t);
    int  eff;
    logic a, b;
    eff = (d < p) ? d : p;
    a = (pos < eff);
    b = (pos >= eff + t) && (pos + t < p);
    return {a, b};
  endfunction

  always @(posedge clk) begin : model
    int vi, th, cl, pin;
    logic [1:0] pr;
    vi  = v_out_code;
    th  = ov_thresh;
    cl  = ov_clear;
    pin = period;
    if (rst) begin
      m_run = 1'b0; m_flt = 1'b0; m_pos = 0; m_p = 0; m_d = 0; m_t = 0;
    end else if (m_flt) begin
      if (vi <= cl && !en) m_flt = 1'b0;
    end else if (m_run) begin
      if (vi >= th) begin
        m_run = 1'b0; m_flt = 1'b1; m_pos = 0;
      end else if (m_pos == m_p - 1) begin
        m_pos = 0;
        if (en) begin m_p = pin; m_d = duty; m_t = dead; end
        else m_run = 1'b0;
      end else begin
        m_pos = m_pos + 1;
      end
    end else if (en) begin
      if (vi >= th) m_flt = 1'b1;
      else if (pin >= 2) begin
        m_run = 1'b1; m_pos = 0; m_p = pin; m_d = duty; m_t = dead;
      end
    end
    if (m_run) begin
      pr = pwm_pair(m_pos, m_p, m_d, m_t);
      exp_q.push_back({pr, 1'b0, (m_pos == 0), 1'b1});
    end else begin
      exp_q.push_back({2'b00, m_flt, 2'b00});
    end
  end

  always @(negedge clk) begin : monitor
    logic [4:0] e, a;
    a = {sw1, sw2, fault, cycle_start, busy};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t {sw1,sw2,fault,cycle_start,busy} got %b expected %b", $time, a, e);
      end
    end
    n_checks++;
    if ((sw1 & sw2) !== 1'b0) begin
      n_fail++;
      $display("FAIL overlap t=%0t sw1=%b sw2=%b expected never both 1", $time, sw1, sw2);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cs;
    int k;
    k = 0;
    while (cycle_start !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL wait_cs cycle_start=%b after %0d cycles, expected a pulse", cycle_start, k);
    end
  endtask

  initial begin : stim
    int r, tmp;
    rst = 1'b1; en = 1'b0; period = 16'd10; duty = 16'd4; dead = 8'd1;
    v_out_code = '0; ov_thresh = 25'sd1000; ov_clear = 25'sd800;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Basic PWM, then boundary duty/dead values picked up at period boundaries.
    en = 1'b1;
    tick(35);
    duty = 16'd0;  tick(20);
    duty = 16'd12; tick(20);
    duty = 16'd4; dead = 8'd5; tick(20);
    dead = 8'd1; tick(10);

    // Mid-period parameter change at cnt=3.
    wait_cs; tick(3);
    period = 16'd6; duty = 16'd2;
    tick(20);
    period = 16'd10; duty = 16'd4;
    tick(12);

    // Graceful stop at cnt=2.
    wait_cs; tick(2);
    en = 1'b0;
    tick(15);

    // period=1 never starts.
    period = 16'd1; en = 1'b1; tick(6);
    en = 1'b0; period = 16'd10; tick(2);

    // Over-voltage and hysteresis.
    en = 1'b1; tick(2);
    wait_cs; tick(1);
    v_out_code = 25'sd1000; tick(2);
    v_out_code = 25'sd900; en = 1'b0; tick(3);
    v_out_code = 25'sd800; en = 1'b1; tick(3);
    en = 1'b0; tick(3);
    v_out_code = '0; tick(2);

    // Reset mid-run at cnt=5.
    en = 1'b1; tick(2);
    wait_cs; tick(5);
    rst = 1'b1; tick(1);
    rst = 1'b0; en = 1'b0; tick(3);

    // Random sweep.
    for (int i = 0; i < 1500; i++) begin
      period = 16'($urandom_range(2, 40));
      duty   = 16'($urandom_range(0, 45));
      dead   = 8'($urandom_range(0, 25));
      r      = int'($urandom_range(0, 99));
      en     = (r >= 8);
      rst    = (r == 99);
      if (r < 3) begin
        tmp = int'($urandom_range(900, 1100));
        v_out_code = 25'(tmp);
      end else if (r < 6) begin
        tmp = int'($urandom_range(0, 5000));
        v_out_code = 25'(-tmp);
      end else begin
        tmp = int'($urandom_range(0, 799));
        v_out_code = 25'(tmp);
      end
      tick(int'($urandom_range(1, 30)));
      rst = 1'b0;
    end

    en = 1'b0; v_out_code = '0;
    tick(5);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
